lcd_fetch_arb: RTL and testbench

Screen-refresh fetch sequencer and memory-bus arbiter for the LCD path. Reads attribute pairs from the screen base file, resolves each character code to one of the four font tables (lores0/lores1/hires0/hires1), fetches the glyph byte, and hands `{attr, glyph}` to the LCD shifter. Shares the 22-bit physical bus `ma` with the Z80, which always has priority. An optional starvation guard can stall the CPU.

---
 rtl/lcd_fetch_arb.sv | 211 +++++++++++++++++++++
 tb/tb_lcd_fetch_arb.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_fetch_arb.sv
`default_nettype none
// =====================================================================
// Module   : lcd_fetch_arb
// Desc     : LCD refresh fetch sequencer and memory-bus arbiter. Reads
//            attribute pairs from the screen base, resolves the font
//            table, fetches the glyph byte and presents {attr, glyph}.
//            The Z80 always has bus priority.
// Options  : `define LCD_FETCH_WAIT_EN enables the CPU starvation guard
// Revision : 1.0  initial release
// =====================================================================
module lcd_fetch_arb #(
  parameter int NCOLS  = 108,
  parameter int STARVE = 16
) (
  input  logic        mck,
  input  logic        rin,
  input  logic        lcd_en,
  input  logic [10:0] sbr,
  input  logic [12:0] pb0,
  input  logic [9:0]  pb1,
  input  logic [8:0]  pb2,
  input  logic [10:0] pb3,
  input  logic        line_start,
  input  logic [2:0]  row,
  input  logic [2:0]  line,
  input  logic        cpu_req,
  input  logic [21:0] cpu_ma,
  output logic [21:0] ma,
  output logic        lcd_rd,
  input  logic [7:0]  mdi,
  output logic [7:0]  out_data,
  output logic [7:0]  out_attr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        line_done,
  output logic        cpu_wait_n
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ALO  = 3'd1,
    ST_AHI  = 3'd2,
    ST_GLY  = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  localparam logic [6:0] LAST_COL = 7'(NCOLS - 1);

  // Column counter is 7 bits and the guard counter is 5 bits
  if (NCOLS < 1 || NCOLS > 128 || STARVE < 1 || STARVE > 31) begin : g_param_check
    $error("lcd_fetch_arb: NCOLS or STARVE out of range");
  end

  state_t      state;
  logic        phase_s;      // 0 = address phase, 1 = sample phase
  logic [6:0]  col;
  logic [2:0]  row_q;
  logic [2:0]  line_q;
  logic [7:0]  lo_q;
  logic [7:0]  hi_q;
  logic [7:0]  gly_q;        // glyph parked while the output is full

  logic        fetching;
  logic        granted;
  logic        can_load;
  logic        do_load;
  logic [7:0]  load_byte;
  logic [21:0] scr_addr;
  logic [21:0] gly_addr;
  logic [21:0] fetch_addr;
  logic [8:0]  lores_code;
  logic [9:0]  hires_code;

  assign fetching   = (state == ST_ALO) || (state == ST_AHI) || (state == ST_GLY);
  assign can_load   = !out_valid || out_ready;
  assign do_load    = can_load &&
                      ((state == ST_HOLD) || ((state == ST_GLY) && phase_s && granted));
  assign load_byte  = (state == ST_HOLD) ? gly_q : mdi;

  assign scr_addr   = {sbr, row_q, col, 1'b0};
  assign lores_code = {hi_q[0], lo_q};
  assign hires_code = {hi_q[1:0], lo_q};

  // Font table selection from the character code
  always_comb begin
    gly_addr = {pb1, lores_code, line_q};
    if (!hi_q[5]) begin
      if (lores_code >= 9'h1C0) gly_addr = {pb0, lores_code[5:0], line_q};
    end else begin
      if (hires_code < 10'h300) gly_addr = {pb2, hires_code, line_q};
      else                      gly_addr = {pb3, hires_code[7:0], line_q};
    end
  end

  // Address presented by the fetch engine for the current state
  always_comb begin
    case (state)
      ST_AHI:  fetch_addr = {scr_addr[21:1], 1'b1};
      ST_GLY:  fetch_addr = gly_addr;
      default: fetch_addr = scr_addr;
    endcase
  end

  assign lcd_rd = fetching && granted;
  assign ma     = lcd_rd ? fetch_addr : cpu_ma;

`ifdef LCD_FETCH_WAIT_EN
  localparam logic [4:0] STARVE_LIM = 5'(STARVE);

  logic [4:0] starve_cnt;
  logic       force_q;

  assign granted    = !cpu_req || force_q;
  assign cpu_wait_n = !force_q;

  // Count consecutive blocked fetch cycles; once the limit is reached, stall the CPU for one access
  always_ff @(posedge mck) begin
    if (rin || !lcd_en || line_start || !fetching) begin
      starve_cnt <= 5'd0;
      force_q    <= 1'b0;
    end else if (phase_s && granted) begin
      starve_cnt <= 5'd0;
      force_q    <= 1'b0;
    end else if (!granted) begin
      if (starve_cnt == STARVE_LIM) force_q <= 1'b1;
      else                          starve_cnt <= starve_cnt + 5'd1;
    end else if (!force_q) begin
      starve_cnt <= 5'd0;
    end
  end
`else
  assign granted    = !cpu_req;
  assign cpu_wait_n = 1'b1;
`endif

  // Fetch sequencer, output register and line bookkeeping
  always_ff @(posedge mck) begin
    line_done <= 1'b0;
    if (rin) begin
      state     <= ST_IDLE;
      phase_s   <= 1'b0;
      col       <= 7'd0;
      row_q     <= 3'd0;
      line_q    <= 3'd0;
      lo_q      <= 8'd0;
      hi_q      <= 8'd0;
      gly_q     <= 8'd0;
      out_data  <= 8'd0;
      out_attr  <= 8'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (!lcd_en) begin
      state     <= ST_IDLE;
      phase_s   <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else if (line_start) begin
      // Abandon any line in progress; a pending output is kept
      row_q   <= row;
      line_q  <= line;
      col     <= 7'd0;
      state   <= ST_ALO;
      phase_s <= 1'b0;
      busy    <= 1'b1;
      if (out_ready) out_valid <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (do_load) begin
        out_data  <= load_byte;
        out_attr  <= hi_q;
        out_valid <= 1'b1;
        col       <= col + 7'd1;
        phase_s   <= 1'b0;
        if (col == LAST_COL) begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          line_done <= 1'b1;
        end else begin
          state <= ST_ALO;
        end
      end else if (fetching) begin
        if (!granted) begin
          // CPU took the bus: the access restarts from its address phase
          phase_s <= 1'b0;
        end else if (!phase_s) begin
          phase_s <= 1'b1;
        end else begin
          phase_s <= 1'b0;
          case (state)
            ST_ALO: begin
              lo_q  <= mdi;
              state <= ST_AHI;
            end
            ST_AHI: begin
              hi_q  <= mdi;
              state <= ST_GLY;
            end
            default: begin
              // Glyph arrived but the output register is still full
              gly_q <= mdi;
              state <= ST_HOLD;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_fetch_arb.sv
`default_nettype none
// =====================================================================
// Module   : tb_lcd_fetch_arb
// Desc     : Self-checking bench for lcd_fetch_arb (NCOLS = 4).
// Revision : 1.0  initial release
// =====================================================================
module tb_lcd_fetch_arb;

  localparam int NC = 4;

  logic        mck = 1'b0;
  logic        rin;
  logic        lcd_en;
  logic [10:0] sbr;
  logic [12:0] pb0;
  logic [9:0]  pb1;
  logic [8:0]  pb2;
  logic [10:0] pb3;
  logic        line_start;
  logic [2:0]  row;
  logic [2:0]  line;
  logic        cpu_req;
  logic [21:0] cpu_ma;
  logic [21:0] ma;
  logic        lcd_rd;
  logic [7:0]  mdi;
  logic [7:0]  out_data;
  logic [7:0]  out_attr;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        line_done;
  logic        cpu_wait_n;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ld_cnt   = 0;
  int          seed     = 0;
  logic [7:0]  scr [int];
  logic [15:0] exp_q [$];

  lcd_fetch_arb #(.NCOLS(NC), .STARVE(16)) dut (
    .mck(mck), .rin(rin), .lcd_en(lcd_en), .sbr(sbr),
    .pb0(pb0), .pb1(pb1), .pb2(pb2), .pb3(pb3),
    .line_start(line_start), .row(row), .line(line),
    .cpu_req(cpu_req), .cpu_ma(cpu_ma), .ma(ma), .lcd_rd(lcd_rd),
    .mdi(mdi), .out_data(out_data), .out_attr(out_attr),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .line_done(line_done), .cpu_wait_n(cpu_wait_n)
  );

  always #5 mck = ~mck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory image: explicit entries, otherwise a seeded hash of the address
  function automatic logic [7:0] mem_rd(input logic [21:0] a);
    int v;
    if (scr.exists(int'(a))) return scr[int'(a)];
    v = int'(a) * 151 + (int'(a) >>> 9) + seed;
    return v[7:0];
  endfunction

  // Glyph address from the font-table rules, in plain arithmetic
  function automatic int glyph_addr(input int hi, input int lo, input int ln);
    int code;
    if ((hi & 32) == 0) begin
      code = (hi & 1) * 256 + lo;
      if (code < 448) return int'(pb1) * 4096 + code * 8 + ln;
      return int'(pb0) * 512 + (code % 64) * 8 + ln;
    end
    code = (hi & 3) * 256 + lo;
    if (code < 768) return int'(pb2) * 8192 + code * 8 + ln;
    return int'(pb3) * 2048 + (code % 256) * 8 + ln;
  endfunction

  // Expected {attr, glyph} stream for the first n columns of the current line
  task automatic model_line(input int n);
    for (int c = 0; c < n; c++) begin
      int sa, lo, hi, ga;
      sa = int'(sbr) * 2048 + int'(row) * 256 + c * 2;
      lo = int'(mem_rd(22'(sa)));
      hi = int'(mem_rd(22'(sa + 1)));
      ga = glyph_addr(hi, lo, int'(line));
      exp_q.push_back({8'(hi), mem_rd(22'(ga))});
    end
  endtask

  // Memory responds combinationally to the stable address
  always @(posedge mck) begin
    #2;
    mdi = mem_rd(ma);
  end

  // Consumer scoreboard, line_done counter and CPU-priority monitor
  always @(negedge mck) begin
    if (!rin) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_push", 32'd1, 32'd0);
        else chk("push", {out_attr, out_data}, exp_q.pop_front());
      end
      if (line_done) ld_cnt++;
      if (cpu_req && cpu_wait_n) begin
        chk("cpu_owns_ma", ma, cpu_ma);
        chk("cpu_no_rd", lcd_rd, 1'b0);
      end
`ifndef LCD_FETCH_WAIT_EN
      chk("wait_n_high", cpu_wait_n, 1'b1);
`endif
    end
  end

  task automatic step();
    @(posedge mck);
    #1;
  endtask

  task automatic start_line();
    step();
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  task automatic finish_line(input int bound, input bit rnd);
    int n;
    n = 0;
    while (busy && n < bound) begin
      step();
      if (rnd) begin
        cpu_req   = ($urandom_range(0, 3) == 0);
        cpu_ma    = 22'($urandom);
        out_ready = ($urandom_range(0, 2) != 0);
      end
      n++;
    end
    chk("line_timeout", 32'(n < bound), 32'd1);
    cpu_req   = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    @(negedge mck);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("line_done_cnt", ld_cnt, 32'd1);
  endtask

  task automatic basic_setup();
    sbr = 11'h001; row = 3'd2; line = 3'd5;
    pb0 = 13'h0F0F; pb1 = 10'h005; pb2 = 9'h1A5; pb3 = 11'h35A;
    exp_q.delete();
    ld_cnt = 0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sa0;
    int n;
    logic [15:0] first;
    rin = 1'b1; lcd_en = 1'b0; line_start = 1'b0; cpu_req = 1'b0;
    cpu_ma = 22'h2ABCDE; out_ready = 1'b0; sbr = '0; row = '0; line = '0;
    pb0 = '0; pb1 = '0; pb2 = '0; pb3 = '0;
    seed = int'($urandom_range(0, 255));
    scr[32'h000A00] = 8'h41;
    scr[32'h000A01] = 8'h00;
    repeat (3) step();
    rin = 1'b0;
    @(negedge mck);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd", lcd_rd, 1'b0);
    chk("rst_done", line_done, 1'b0);
    chk("rst_wait_n", cpu_wait_n, 1'b1);
    chk("rst_ma", ma, 22'h2ABCDE);
    chk("rst_data", {out_attr, out_data}, 16'h0000);

    // Basic glyph fetch with exact cycle timing
    lcd_en = 1'b1; out_ready = 1'b1;
    basic_setup();
    model_line(NC);
    start_line();
    @(negedge mck);
    chk("alo_addr", ma, 22'h000A00);
    chk("alo_rd", lcd_rd, 1'b1);
    chk("busy_on", busy, 1'b1);
    step(); step(); @(negedge mck);
    chk("ahi_addr", ma, 22'h000A01);
    step(); step(); @(negedge mck);
    chk("gly_addr", ma, 22'h00520D);
    step(); @(negedge mck);
    chk("valid_e5", out_valid, 1'b0);
    step(); @(negedge mck);
    chk("valid_e6", out_valid, 1'b1);
    chk("basic_data", out_data, mem_rd(22'h00520D));
    chk("basic_attr", out_attr, 8'h00);
    finish_line(400, 1'b0);

    // Font region boundaries: 0x1BF/0x1C0 lores, 0x2FF/0x300 hires
    sbr = 11'h3C5; row = 3'd1; line = 3'd3;
    pb0 = 13'h1234; pb1 = 10'h2AB; pb2 = 9'h0CD; pb3 = 11'h5E1;
    sa0 = int'(sbr) * 2048 + int'(row) * 256;
    scr[sa0 + 0] = 8'hBF; scr[sa0 + 1] = 8'h01;
    scr[sa0 + 2] = 8'hC0; scr[sa0 + 3] = 8'h01;
    scr[sa0 + 4] = 8'hFF; scr[sa0 + 5] = 8'h22;
    scr[sa0 + 6] = 8'h00; scr[sa0 + 7] = 8'h23;
    scr[int'(pb1) * 4096 + 'h1BF * 8 + 3]  = 8'h11;
    scr[int'(pb0) * 512 + 0 * 8 + 3]       = 8'h22;
    scr[int'(pb2) * 8192 + 'h2FF * 8 + 3]  = 8'h33;
    scr[int'(pb3) * 2048 + 0 * 8 + 3]      = 8'h44;
    exp_q.delete(); ld_cnt = 0;
    model_line(NC);
    start_line();
    finish_line(400, 1'b0);

    // CPU contention during AHI sample phase
    basic_setup();
    model_line(NC);
    start_line();
    step(); step(); step();
    cpu_req = 1'b1; cpu_ma = 22'h155555;
    @(negedge mck); chk("cont_rd_0", lcd_rd, 1'b0);
    step(); @(negedge mck); chk("cont_rd_1", lcd_rd, 1'b0);
    step(); @(negedge mck); chk("cont_rd_2", lcd_rd, 1'b0);
    step();
    cpu_req = 1'b0;
    @(negedge mck);
    chk("ahi_restart_addr", ma, 22'h000A01);
    chk("ahi_restart_rd", lcd_rd, 1'b1);
    step(); step(); @(negedge mck);
    chk("post_cont_gly", ma, 22'h00520D);
    finish_line(400, 1'b0);

    // Backpressure: output full forces HOLD
    basic_setup();
    model_line(NC);
    out_ready = 1'b0;
    start_line();
    repeat (6) step();
    @(negedge mck);
    chk("bp_valid", out_valid, 1'b1);
    first = exp_q[0];
    repeat (8) step();
    @(negedge mck);
    chk("hold_no_rd", lcd_rd, 1'b0);
    chk("hold_busy", busy, 1'b1);
    chk("hold_data", {out_attr, out_data}, first);
    step(); step();
    out_ready = 1'b1;
    finish_line(400, 1'b0);

    // Mid-line restart at column 2
    basic_setup();
    out_ready = 1'b1;
    model_line(2);
    start_line();
    repeat (13) step();
    row = 3'd3;
    model_line(NC);
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    @(negedge mck);
    chk("restart_no_done", ld_cnt, 32'd0);
    chk("restart_col0", ma, 22'h000B00);
    finish_line(400, 1'b0);

    // lcd_en low drops to IDLE and clears out_valid
    basic_setup();
    out_ready = 1'b0;
    start_line();
    repeat (6) step();
    @(negedge mck);
    chk("dis_pre_valid", out_valid, 1'b1);
    step();
    lcd_en = 1'b0;
    step();
    @(negedge mck);
    chk("dis_valid", out_valid, 1'b0);
    chk("dis_busy", busy, 1'b0);
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    step();
    @(negedge mck);
    chk("dis_ignore_start", busy, 1'b0);
    chk("dis_no_done", ld_cnt, 32'd0);
    step();
    lcd_en = 1'b1;
    out_ready = 1'b1;

    // CPU stuck on the bus
    basic_setup();
    model_line(NC);
    start_line();
    cpu_req = 1'b1;
`ifdef LCD_FETCH_WAIT_EN
    n = 0;
    while (cpu_wait_n && n < 60) begin step(); n++; end
    chk("starve_fired", 32'(!cpu_wait_n), 32'd1);
    chk("starve_delay", 32'(n >= 16), 32'd1);
    n = 0;
    while (!cpu_wait_n && n < 10) begin step(); n++; end
    chk("starve_release", cpu_wait_n, 1'b1);
`else
    repeat (40) step();
    @(negedge mck);
    chk("stall_no_push", out_valid, 1'b0);
    chk("stall_busy", busy, 1'b1);
    chk("stall_wait_n", cpu_wait_n, 1'b1);
`endif
    cpu_req = 1'b0;
    finish_line(400, 1'b0);

    // Randomized lines against the reference model
    for (int k = 0; k < 8; k++) begin
      sbr = 11'($urandom); row = 3'($urandom); line = 3'($urandom);
      pb0 = 13'($urandom); pb1 = 10'($urandom); pb2 = 9'($urandom); pb3 = 11'($urandom);
      seed = int'($urandom_range(0, 255));
      exp_q.delete(); ld_cnt = 0;
      model_line(NC);
      start_line();
      finish_line(2000, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
